// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer
// Triggered capture of ADC samples into a circular RAM. Samples are written
// continuously once armed. A level crossing (or a forced trigger) freezes a
// window of PRE_TRIG samples before the trigger sample, the trigger sample
// itself and DEPTH-PRE_TRIG-1 samples after it. The frozen window is then
// streamed out oldest-first, one sample per request, with one cycle of latency.
module adc_capture_buffer #(
    parameter int DATA_W   = 12,
    parameter int ADDR_W   = 8,
    parameter int PRE_TRIG = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              sample_valid_i,
    input  logic              arm_i,
    input  logic [DATA_W-1:0] trig_level_i,
    input  logic              trig_rising_i,
    input  logic              force_trig_i,
    input  logic              rd_req_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              rd_last_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int DEPTH = 1 << ADDR_W;

    // Number of pre-trigger samples, as an address offset.
    localparam logic [ADDR_W-1:0] PRE_A     = ADDR_W'(PRE_TRIG);
    // Samples still to be written after the trigger sample.
    localparam logic [ADDR_W-1:0] POST_INIT = ADDR_W'(DEPTH - PRE_TRIG - 1);
    // Index of the final read of the window.
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    state_t              state_q,      state_d;
    logic [ADDR_W-1:0]   wr_ptr_q,     wr_ptr_d;
    logic [ADDR_W-1:0]   fill_cnt_q,   fill_cnt_d;
    logic                prev_vld_q,   prev_vld_d;
    logic                force_pend_q, force_pend_d;
    logic [ADDR_W-1:0]   trig_addr_q,  trig_addr_d;
    logic [ADDR_W-1:0]   post_cnt_q,   post_cnt_d;
    logic [ADDR_W-1:0]   rd_ptr_q,     rd_ptr_d;
    logic [ADDR_W-1:0]   rd_cnt_q,     rd_cnt_d;
    logic                rd_valid_q,   rd_valid_d;
    logic                rd_last_q,    rd_last_d;
    logic                busy_q,       busy_d;
    logic                done_q,       done_d;

    logic                wr_en;
    logic                rd_en;
    logic                trig_hit;

    // Sample storage and the previous-sample register are pure datapath;
    // their contents are only trusted when the matching control flag is set.
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   prev_smp_q;
    logic [DATA_W-1:0]   ram_dout_q;

    // Unsigned level-crossing test between the previous and current sample.
    function automatic logic level_cross(
        input logic [DATA_W-1:0] prev,
        input logic [DATA_W-1:0] cur,
        input logic [DATA_W-1:0] lvl,
        input logic              rising
    );
        if (rising) begin
            return (prev < lvl) && (cur >= lvl);
        end
        return (prev >= lvl) && (cur < lvl);
    endfunction

    // Control state register; everything here is cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            fill_cnt_q   <= '0;
            prev_vld_q   <= 1'b0;
            force_pend_q <= 1'b0;
            trig_addr_q  <= '0;
            post_cnt_q   <= '0;
            rd_ptr_q     <= '0;
            rd_cnt_q     <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_cnt_q   <= fill_cnt_d;
            prev_vld_q   <= prev_vld_d;
            force_pend_q <= force_pend_d;
            trig_addr_q  <= trig_addr_d;
            post_cnt_q   <= post_cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Next-state, pointer and counter logic for the capture/readout FSM.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        fill_cnt_d   = fill_cnt_q;
        prev_vld_d   = prev_vld_q;
        force_pend_d = force_pend_q;
        trig_addr_d  = trig_addr_q;
        post_cnt_d   = post_cnt_q;
        rd_ptr_d     = rd_ptr_q;
        rd_cnt_d     = rd_cnt_q;
        rd_valid_d   = 1'b0;
        rd_last_d    = 1'b0;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        trig_hit     = 1'b0;

        // Status outputs are a one-cycle-delayed decode of the state register.
        busy_d = (state_q == S_FILL) || (state_q == S_ARMED) || (state_q == S_POST);
        done_d = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (arm_i) begin
                    wr_ptr_d     = '0;
                    fill_cnt_d   = '0;
                    prev_vld_d   = 1'b0;
                    force_pend_d = 1'b0;
                    state_d      = (PRE_TRIG == 0) ? S_ARMED : S_FILL;
                end
            end

            S_FILL: begin
                if (force_trig_i) begin
                    force_pend_d = 1'b1;
                end
                if (sample_valid_i) begin
                    wr_en      = 1'b1;
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                    prev_vld_d = 1'b1;
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if (fill_cnt_d == PRE_A) begin
                        state_d = S_ARMED;
                    end
                end
            end

            S_ARMED: begin
                if (force_trig_i) begin
                    force_pend_d = 1'b1;
                end
                if (sample_valid_i) begin
                    wr_en      = 1'b1;
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                    prev_vld_d = 1'b1;
                    trig_hit   = force_pend_q || force_trig_i ||
                                 (prev_vld_q && level_cross(prev_smp_q, sample_i,
                                                            trig_level_i, trig_rising_i));
                    if (trig_hit) begin
                        force_pend_d = 1'b0;
                        trig_addr_d  = wr_ptr_q;
                        post_cnt_d   = POST_INIT;
                        if (POST_INIT == '0) begin
                            // The trigger sample completes the window.
                            state_d  = S_DONE;
                            rd_ptr_d = wr_ptr_q - PRE_A;
                            rd_cnt_d = '0;
                        end else begin
                            state_d  = S_POST;
                        end
                    end
                end
            end

            S_POST: begin
                if (sample_valid_i) begin
                    wr_en      = 1'b1;
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                    post_cnt_d = post_cnt_q - 1'b1;
                    if (post_cnt_q == ADDR_W'(1)) begin
                        // Oldest sample of the window sits PRE_TRIG before the trigger.
                        state_d  = S_DONE;
                        rd_ptr_d = trig_addr_q - PRE_A;
                        rd_cnt_d = '0;
                    end
                end
            end

            S_DONE: begin
                if (rd_req_i) begin
                    rd_en      = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    rd_cnt_d   = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == LAST_IDX) begin
                        // Final read issued: later requests fall into IDLE and are ignored.
                        rd_last_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sample RAM write/read ports and previous-sample capture (no reset needed).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= sample_i;
            prev_smp_q    <= sample_i;
        end
        if (rd_en) begin
            ram_dout_q <= mem[rd_ptr_q];
        end
    end

    // Read data is presented only alongside its valid pulse, so it is zero
    // out of reset even though the RAM output register is not reset.
    assign rd_data_o  = rd_valid_q ? ram_dout_q : '0;
    assign rd_valid_o = rd_valid_q;
    assign rd_last_o  = rd_last_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Directed testbench for adc_capture_buffer: rising/falling/forced triggers,
// pointer wrap, handshake corner cases and mid-capture reset.
module tb_adc_capture_buffer;

    localparam int DATA_W   = 12;
    localparam int ADDR_W   = 8;
    localparam int PRE_TRIG = 64;
    localparam int DEPTH    = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] sample_i;
    logic              sample_valid_i;
    logic              arm_i;
    logic [DATA_W-1:0] trig_level_i;
    logic              trig_rising_i;
    logic              force_trig_i;
    logic              rd_req_i;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_valid_o;
    logic              rd_last_o;
    logic              busy_o;
    logic              done_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] got_d [DEPTH];
    logic              got_l [DEPTH];
    int                got_n;

    adc_capture_buffer #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .PRE_TRIG(PRE_TRIG)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_i      (sample_i),
        .sample_valid_i(sample_valid_i),
        .arm_i         (arm_i),
        .trig_level_i  (trig_level_i),
        .trig_rising_i (trig_rising_i),
        .force_trig_i  (force_trig_i),
        .rd_req_i      (rd_req_i),
        .rd_data_o     (rd_data_o),
        .rd_valid_o    (rd_valid_o),
        .rd_last_o     (rd_last_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Input stream for each scenario.
    function automatic logic [DATA_W-1:0] smp_val(input int t, input int i);
        case (t)
            1, 5:    return DATA_W'(i * 16);
            2:       return (i < 100) ? 12'h800 : 12'h100;
            3:       return 12'h123;
            default: return DATA_W'(i);
        endcase
    endfunction

    // Expected frozen window, oldest first, worked out by hand per scenario.
    function automatic logic [DATA_W-1:0] exp_val(input int t, input int k);
        case (t)
            1, 5:    return DATA_W'(k * 16);          // trigger at 0x400 = index 64
            2:       return (k < 64) ? 12'h800 : 12'h100;
            3:       return 12'h123;
            default: return DATA_W'(936 + k);        // trigger at 1000, window 936..1191
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] v);
        sample_i       = v;
        sample_valid_i = 1'b1;
        tick();
        sample_valid_i = 1'b0;
        repeat (3) tick();
    endtask

    task automatic do_arm();
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        tick();
        chk("busy_after_arm", {31'd0, busy_o}, 32'd1);
        chk("done_after_arm", {31'd0, done_o}, 32'd0);
    endtask

    // Feed samples until done_o rises; n = samples fed, or -1 on timeout.
    task automatic feed(input int t, input int maxn, output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        while (n < maxn && !seen) begin
            if (t == 1 && n == 64) begin
                rd_req_i = 1'b1;
                repeat (3) begin
                    tick();
                    chk("rd_ignored_armed", {31'd0, rd_valid_o}, 32'd0);
                end
                rd_req_i = 1'b0;
            end
            if (t == 1 && n == 100) begin
                arm_i = 1'b1;
                tick();
                arm_i = 1'b0;
                chk("arm_ignored_post", {31'd0, busy_o}, 32'd1);
            end
            if (t == 3 && n == 10) begin
                force_trig_i = 1'b1;
                tick();
                force_trig_i = 1'b0;
            end
            send(smp_val(t, n));
            n++;
            if (done_o) seen = 1'b1;
        end
        if (!seen) n = -1;
    endtask

    // Hold rd_req_i for 300 cycles, collect the window and compare it.
    task automatic readout(input int t);
        for (int k = 0; k < DEPTH; k++) begin
            got_d[k] = '0;
            got_l[k] = 1'b0;
        end
        got_n    = 0;
        rd_req_i = 1'b1;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (rd_valid_o) begin
                if (got_n < DEPTH) begin
                    got_d[got_n] = rd_data_o;
                    got_l[got_n] = rd_last_o;
                end
                got_n++;
            end
        end
        rd_req_i = 1'b0;
        tick();
        chk("rd_count", got_n, DEPTH);
        for (int k = 0; k < DEPTH; k++) begin
            chk($sformatf("rd_data[%0d]", k), {20'd0, got_d[k]}, {20'd0, exp_val(t, k)});
            chk($sformatf("rd_last[%0d]", k), {31'd0, got_l[k]}, (k == DEPTH - 1) ? 32'd1 : 32'd0);
        end
        chk("done_after_rd", {31'd0, done_o}, 32'd0);
        chk("busy_after_rd", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic run(input int t, input logic [DATA_W-1:0] lvl, input logic rising,
                       input int exp_n);
        int n;
        trig_level_i  = lvl;
        trig_rising_i = rising;
        do_arm();
        feed(t, exp_n + 20, n);
        chk($sformatf("samples_to_done_t%0d", t), n, exp_n);
        readout(t);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rd_data"},  {20'd0, rd_data_o},  32'd0);
        chk({tag, "_rd_valid"}, {31'd0, rd_valid_o}, 32'd0);
        chk({tag, "_rd_last"},  {31'd0, rd_last_o},  32'd0);
        chk({tag, "_busy"},     {31'd0, busy_o},     32'd0);
        chk({tag, "_done"},     {31'd0, done_o},     32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        sample_i       = '0;
        sample_valid_i = 1'b0;
        arm_i          = 1'b0;
        trig_level_i   = '0;
        trig_rising_i  = 1'b1;
        force_trig_i   = 1'b0;
        rd_req_i       = 1'b0;
        repeat (3) tick();
        chk_outputs_zero("reset");
        reset = 1'b0;
        tick();

        // Rising ramp, with ignored read request in ARMED and ignored arm in POST.
        run(1, 12'h400, 1'b1, 256);
        // Falling step: 100 x 0x800 then 0x100 triggers at sample 100.
        run(2, 12'h400, 1'b0, 292);
        // Forced trigger latched during FILL on flat data.
        run(3, 12'h400, 1'b1, 256);
        // Long run wraps the write pointer before the trigger at sample 1000.
        run(4, 12'd1000, 1'b1, 1192);

        // Reset while in POST, then a fresh capture.
        trig_level_i  = 12'h400;
        trig_rising_i = 1'b1;
        do_arm();
        for (int i = 0; i < 150; i++) send(smp_val(1, i));
        chk("busy_in_post", {31'd0, busy_o}, 32'd1);
        reset = 1'b1;
        #1;
        chk_outputs_zero("midreset");
        tick();
        reset = 1'b0;
        tick();
        run(5, 12'h400, 1'b1, 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
